fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, framebuffer word-address width (512 x 16-bit words, 128x64 hires field).
REQ-002 Parameter DATA_W, default 16, framebuffer word width (16 pixels per word, MSB leftmost).
REQ-003 clk  in  1  single clock; all logic posedge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 hires  in  1  field mode: 1 = 128x64 (512 words), 0 = 64x32 (128 words).
REQ-006 disp_req  in  1  display fetch request, level, sampled each cycle.
REQ-007 disp_addr  in  ADDR_W  display fetch word address.
REQ-008 disp_data  out  DATA_W  display fetch data.
REQ-009 disp_valid  out  1  disp_data valid strobe.
REQ-010 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-011 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high.
REQ-012 cpu_addr  in  ADDR_W  CPU word address; stable while cpu_req high.
REQ-013 cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req high.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ack=1.
REQ-016 clr_start  in  1  one-cycle pulse: zero the active field.
REQ-017 clr_busy  out  1  clear in progress.
REQ-018 ram_addr  out  ADDR_W  framebuffer RAM address.
REQ-019 ram_we  out  1  framebuffer RAM write enable.
REQ-020 ram_wdata  out  DATA_W  framebuffer RAM write data.
REQ-021 ram_rdata  in  DATA_W  RAM read data, registered, one cycle after ram_addr.

Function
REQ-022 Exactly one requester owns the RAM port per cycle; fixed priority display > clear > CPU.
REQ-023 Display grant: disp_req=1 in cycle N -> ram_addr=disp_addr, ram_we=0 in N (combinational); disp_valid=1 and disp_data=ram_rdata in N+1; never stalled.
REQ-024 FSM states IDLE, CPU_WAIT, CLEAR.
REQ-025 IDLE: clr_start=1 -> CLEAR, clear counter := 0; else cpu_req=1 and disp_req=0 -> issue CPU access this cycle, -> CPU_WAIT; clr_start takes precedence over cpu_req in same cycle.
REQ-026 CPU issue cycle: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
REQ-027 CPU_WAIT (one cycle): cpu_ack=1, cpu_rdata=ram_rdata (reads; don't-care for writes); -> IDLE; no CPU issue in this cycle, so a held cpu_req is not re-granted until the following cycle.
REQ-028 CLEAR: on each cycle with disp_req=0, ram_addr=counter, ram_we=1, ram_wdata=0, counter+1; cycles with disp_req=1 stall counter, no write.
REQ-029 Clear last address = 511 if hires else 127, hires sampled at clr_start and held for the clear; after writing last address -> IDLE; counter never wraps.
REQ-030 clr_busy=1 exactly while in CLEAR; clr_start during CLEAR or CPU_WAIT ignored.
REQ-031 cpu_req during CLEAR held off: no cpu_ack until clear completes and CPU then wins arbitration.
REQ-032 When no grant: ram_we=0, ram_addr=0, ram_wdata=0.
REQ-033 Clear counter ADDR_W bits; address arithmetic modulo 2^ADDR_W, no other wrap.

Reset
REQ-034 reset_n=0 asynchronously: state IDLE, counter 0, disp_valid=0, disp_data=0, cpu_ack=0, cpu_rdata=0, clr_busy=0, ram_we=0.
REQ-035 Reset mid-clear or mid-CPU access aborts it; no ack after reset release; pending cpu_req re-arbitrated from IDLE.

Verification
REQ-036 CPU write 0x1234 @ 0x005, then read @ 0x005, no display traffic -> ack one cycle after each issue; read cpu_rdata=0x1234.
REQ-037 disp_req=1 continuously, cpu_req=1 -> no CPU grant, disp_valid every cycle; drop disp_req -> CPU issued that cycle, ack next cycle.
REQ-038 hires=0, clr_start, no display -> 128 writes of 0 to 0..127, clr_busy high 128 cycles; hires=1 -> 512 writes to 0..511.
REQ-039 Clear with disp_req toggling every other cycle -> writes only on disp_req=0 cycles, addresses contiguous, none skipped or repeated.
REQ-040 clr_start and cpu_req in same IDLE cycle -> clear runs first; cpu_ack only after clr_busy falls.
REQ-041 reset_n low at clear address 40 -> outputs at reset values immediately; after release clr_busy=0, next clr_start restarts at address 0.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: display fetch, CPU access,
// clear control and the single shared RAM port.
interface fb_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic              hires;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              clr_start;
  logic              clr_busy;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  hires,
    input  disp_req,
    input  disp_addr,
    output disp_data,
    output disp_valid,
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_ack,
    output cpu_rdata,
    input  clr_start,
    output clr_busy,
    output ram_addr,
    output ram_we,
    output ram_wdata,
    input  ram_rdata
  );

  modport master (
    output hires,
    output disp_req,
    output disp_addr,
    input  disp_data,
    input  disp_valid,
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_ack,
    input  cpu_rdata,
    output clr_start,
    input  clr_busy,
    input  ram_addr,
    input  ram_we,
    input  ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display > clear > CPU,
// with a hardware field-clear engine.
module fb_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  fb_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_WAIT,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_HI = '1;
  localparam logic [ADDR_W-1:0] LAST_LO = LAST_HI >> 2;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_hires;
  logic              w_hires_nxt;
  logic              r_disp_pend;

  logic              w_gnt_disp;
  logic              w_gnt_clr;
  logic              w_gnt_cpu;
  logic              w_clr_last;

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_wdata;

  // Grants are masked by reset so the port goes quiet at once.
  assign w_gnt_disp = reset_n & bus.disp_req;

  assign w_gnt_clr  = reset_n
                    & (r_state == CLEAR)
                    & ~bus.disp_req;

  assign w_gnt_cpu  = reset_n
                    & (r_state == IDLE)
                    & ~bus.clr_start
                    & bus.cpu_req
                    & ~bus.disp_req;

  assign w_clr_last = (r_cnt == (r_hires ? LAST_HI : LAST_LO));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hires_nxt = r_hires;
    case (r_state)
      IDLE: begin
        if (bus.clr_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_hires_nxt = bus.hires;
        end else if (w_gnt_cpu) begin
          w_state_nxt = CPU_WAIT;
        end
      end
      CPU_WAIT: begin
        w_state_nxt = IDLE;
      end
      CLEAR: begin
        if (w_gnt_clr) begin
          if (w_clr_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_ram_addr  = '0;
    w_ram_we    = 1'b0;
    w_ram_wdata = '0;
    unique case (1'b1)
      w_gnt_disp: begin
        w_ram_addr = bus.disp_addr;
      end
      w_gnt_clr: begin
        w_ram_addr = r_cnt;
        w_ram_we   = 1'b1;
      end
      w_gnt_cpu: begin
        w_ram_addr  = bus.cpu_addr;
        w_ram_we    = bus.cpu_we;
        w_ram_wdata = bus.cpu_wdata;
      end
      default: begin
        w_ram_addr = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hires     <= 1'b0;
      r_disp_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hires     <= w_hires_nxt;
      r_disp_pend <= w_gnt_disp;
    end
  end

  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_wdata  = w_ram_wdata;

  assign bus.disp_valid = r_disp_pend;
  assign bus.disp_data  = r_disp_pend
                        ? bus.ram_rdata
                        : '0;

  assign bus.cpu_ack    = (r_state == CPU_WAIT);
  assign bus.cpu_rdata  = (r_state == CPU_WAIT)
                        ? bus.ram_rdata
                        : '0;

  assign bus.clr_busy   = (r_state == CLEAR);

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: a per-cycle ownership
// model predicts RAM writes, display data and CPU acks.
module tb_fb_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fb_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  fb_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [15:0] mem [512];
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endfunction

  typedef struct { int c; logic [15:0] d; } dexp_t;
  typedef struct { int c; logic [8:0] a; logic [15:0] d; } wexp_t;
  typedef struct { int c; bit rd; logic [15:0] d; } cexp_t;

  dexp_t q_disp [$];
  wexp_t q_wr   [$];
  cexp_t q_cpu  [$];

  logic [15:0] ref_mem [512];

  // Model of who owns the port this cycle
  bit          clr_active = 0;
  int          clr_k = 0;
  int          clr_last = 0;
  bit          cpu_pend = 0;
  bit          cpu_infl = 0;
  bit          c_we = 0;
  logic [8:0]  c_addr = '0;
  logic [15:0] c_wd = '0;

  always @(negedge clk) begin
    dexp_t de;
    wexp_t we;
    cexp_t ce;
    if (bus.disp_valid === 1'b1) begin
      if (q_disp.size() == 0) begin
        chk("disp_unexpected", 1, 0);
      end else begin
        de = q_disp.pop_front();
        chk("disp_cycle", cyc, de.c);
        chk("disp_data", bus.disp_data, de.d);
      end
    end
    if (bus.ram_we === 1'b1) begin
      if (q_wr.size() == 0) begin
        chk("wr_unexpected", {23'd0, bus.ram_addr}, 32'hffff);
      end else begin
        we = q_wr.pop_front();
        chk("wr_cycle", cyc, we.c);
        chk("wr_addr", bus.ram_addr, we.a);
        chk("wr_data", bus.ram_wdata, we.d);
      end
    end
    if (bus.cpu_ack === 1'b1) begin
      if (q_cpu.size() == 0) begin
        chk("ack_unexpected", 1, 0);
      end else begin
        ce = q_cpu.pop_front();
        chk("ack_cycle", cyc, ce.c);
        if (ce.rd) chk("cpu_rdata", bus.cpu_rdata, ce.d);
      end
    end
  end

  task automatic new_cpu(input bit we,
                         input logic [8:0] a,
                         input logic [15:0] d);
    if (!cpu_pend && !cpu_infl) begin
      cpu_pend = 1;
      c_we = we;
      c_addr = a;
      c_wd = d;
    end
  endtask

  task automatic step(input bit dreq,
                      input logic [8:0] da,
                      input bit cst,
                      input bit hi);
    bit busy_exp;
    @(posedge clk);
    #1;
    bus.disp_req  = dreq;
    bus.disp_addr = da;
    bus.clr_start = cst;
    bus.hires     = hi;
    bus.cpu_req   = cpu_pend | cpu_infl;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wd;
    busy_exp = 0;
    if (dreq) q_disp.push_back('{cyc + 1, ref_mem[da]});
    if (clr_active) begin
      busy_exp = 1;
      if (!dreq) begin
        q_wr.push_back('{cyc, clr_k[8:0], 16'h0});
        ref_mem[clr_k] = 16'h0;
        if (clr_k == clr_last) clr_active = 0;
        else clr_k++;
      end
    end else if (cpu_infl) begin
      cpu_infl = 0;
    end else if (cst) begin
      clr_active = 1;
      clr_k = 0;
      clr_last = hi ? 511 : 127;
    end else if (cpu_pend && !dreq) begin
      q_cpu.push_back('{cyc + 1, !c_we, ref_mem[c_addr]});
      if (c_we) begin
        q_wr.push_back('{cyc, c_addr, c_wd});
        ref_mem[c_addr] = c_wd;
      end
      cpu_pend = 0;
      cpu_infl = 1;
    end
    @(negedge clk);
    chk("clr_busy", bus.clr_busy, busy_exp);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ram_we"}, bus.ram_we, 0);
    chk({tag, "_clr_busy"}, bus.clr_busy, 0);
    chk({tag, "_cpu_ack"}, bus.cpu_ack, 0);
    chk({tag, "_disp_valid"}, bus.disp_valid, 0);
    chk({tag, "_disp_data"}, bus.disp_data, 0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
  endtask

  initial begin
    logic [15:0] v;
    bit cst;
    for (int i = 0; i < 512; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    bus.hires = 0;
    bus.disp_req = 0;
    bus.disp_addr = '0;
    bus.cpu_req = 0;
    bus.cpu_we = 0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.clr_start = 0;
    #3;
    chk_reset_outs("rst");
    chk("rst_ram_addr", bus.ram_addr, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    // write then read back at address 5
    new_cpu(1, 9'h005, 16'h1234);
    repeat (3) step(0, '0, 0, 0);
    new_cpu(0, 9'h005, 16'h0);
    repeat (3) step(0, '0, 0, 0);

    // display holds the port off the CPU
    new_cpu(0, 9'h033, 16'h0);
    repeat (10) step(1, 9'($urandom), 0, 0);
    repeat (3) step(0, '0, 0, 0);

    // random display/CPU mix, clr_start only in ack cycles
    for (int i = 0; i < 400; i++) begin
      if (!cpu_pend && !cpu_infl && $urandom_range(0, 2) == 0)
        new_cpu(1'($urandom), 9'($urandom), 16'($urandom));
      cst = cpu_infl && ($urandom_range(0, 7) == 0);
      step(1'($urandom), 9'($urandom), cst, 1'($urandom));
    end
    repeat (3) step(0, '0, 0, 0);

    // lores clear, no display
    step(0, '0, 1, 0);
    for (int i = 0; i < 200 && clr_active; i++)
      step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    // hires clear with CPU racing and display toggling
    new_cpu(0, 9'h010, 16'h0);
    step(0, '0, 1, 1);
    for (int i = 0; i < 1200 && clr_active; i++)
      step(1'(i % 2), 9'($urandom), (i == 50), 0);
    repeat (4) step(0, '0, 0, 0);

    // reset part way through a clear
    step(0, '0, 1, 0);
    for (int i = 0; i < 100 && clr_k != 40; i++)
      step(0, '0, 0, 0);
    @(posedge clk);
    #1 reset_n = 0;
    #1;
    chk_reset_outs("midclr");
    clr_active = 0;
    cpu_infl = 0;
    cpu_pend = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (2) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    for (int i = 0; i < 200 && clr_active; i++)
      step(0, '0, 0, 0);
    repeat (3) step(0, '0, 0, 0);

    chk("disp_q_left", q_disp.size(), 0);
    chk("wr_q_left", q_wr.size(), 0);
    chk("cpu_q_left", q_cpu.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
